i2c_target_regs: RTL

- Synthesizable I2C target (responder) and the bus-side counterpart of the I2C master traffic generator.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and ACKs.
- Maps I2C writes and reads onto a simple 8-bit register-port interface.
- First write byte after the address loads an internal register pointer; the pointer auto-increments after every data byte in either direction.

---
 rtl/i2c_target_regs_if.sv | 31 +++
 rtl/i2c_target_regs.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: register-port bundle between the I2C target and its register file.
// reg_rdy_i is present only when I2C_TARGET_CLK_STRETCH_EN is defined.
interface i2c_target_regs_if;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic [7:0] reg_rdata_i;
  logic       reg_we_o;
  logic       reg_re_o;
  logic       busy_o;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic       reg_rdy_i;
`endif

  modport master (
    output reg_addr_o, reg_wdata_o,
    output reg_we_o, reg_re_o, busy_o,
`ifdef I2C_TARGET_CLK_STRETCH_EN
    input  reg_rdy_i,
`endif
    input  reg_rdata_i
  );

  modport slave (
    input  reg_addr_o, reg_wdata_o,
    input  reg_we_o, reg_re_o, busy_o,
`ifdef I2C_TARGET_CLK_STRETCH_EN
    output reg_rdy_i,
`endif
    output reg_rdata_i
  );
endinterface

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: oversampled I2C target mapping transfers onto an 8-bit register port.
// Define I2C_TARGET_CLK_STRETCH_EN to hold SCL low until reg_rdy_i before each read byte.
module i2c_target_regs #(
  parameter logic [6:0]  TARGET_ADDR = 7'h51,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  output logic scl_o,
  output logic scl_t,
  input  logic sda_i,
  output logic sda_o,
  output logic sda_t,
  i2c_target_regs_if.master rp
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE,
    WR_ACK, RD_BYTE, RD_ACK
  } state_t;

  localparam logic [3:0] FMAX = 4'(FILT_LEN - 1);

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0] s1, s2, filt, filt_q;
  logic [3:0] fcnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '1;
      s2      <= '1;
      filt    <= '1;
      filt_q  <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      s1     <= {sda_i, scl_i};
      s2     <= s1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FMAX) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  logic sda_f, scl_rise, scl_fall, start, stop;
  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_q[0];
  assign scl_fall = ~filt[0] & filt_q[0];
  assign start    = filt[0] & filt_q[0] & filt_q[1] & ~filt[1];
  assign stop     = filt[0] & filt_q[0] & ~filt_q[1] & filt[1];

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sr, sr_n, addr_n, wdata_n;
  logic       first_wr, first_wr_n, rw, rw_n;
  logic       sda_t_n, busy_n, we_n, re_n;
  logic       rd_go, rd_first;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic       hold, hold_n;
`endif

  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      sr             <= '0;
      first_wr       <= 1'b0;
      rw             <= 1'b0;
      sda_t          <= 1'b1;
      rp.busy_o      <= 1'b0;
      rp.reg_addr_o  <= '0;
      rp.reg_wdata_o <= '0;
      rp.reg_we_o    <= 1'b0;
      rp.reg_re_o    <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      sr             <= sr_n;
      first_wr       <= first_wr_n;
      rw             <= rw_n;
      sda_t          <= sda_t_n;
      rp.busy_o      <= busy_n;
      rp.reg_addr_o  <= addr_n;
      rp.reg_wdata_o <= wdata_n;
      rp.reg_we_o    <= we_n;
      rp.reg_re_o    <= re_n;
    end
  end

`ifdef I2C_TARGET_CLK_STRETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold  <= 1'b0;
      scl_t <= 1'b1;
    end else begin
      hold  <= hold_n;
      scl_t <= ~hold;
    end
  end
`else
  assign scl_t = 1'b1;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sr_n       = sr;
    first_wr_n = first_wr;
    rw_n       = rw;
    sda_t_n    = sda_t;
    busy_n     = rp.busy_o;
    addr_n     = rp.reg_addr_o;
    wdata_n    = rp.reg_wdata_o;
    we_n       = 1'b0;
    re_n       = 1'b0;
    rd_go      = 1'b0;
    rd_first   = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    hold_n     = hold;
`endif
    // pointer bump trails the write strobe by one clk
    if (rp.reg_we_o) addr_n = rp.reg_addr_o + 8'd1;
`ifndef I2C_TARGET_CLK_STRETCH_EN
    if (rp.reg_re_o) sr_n = rp.reg_rdata_i;
`endif
    unique case (1'b1)
      stop: begin
        state_n = IDLE;
        sda_t_n = 1'b1;
        busy_n  = 1'b0;
      end
      start: begin
        state_n    = ADDR;
        cnt_n      = '0;
        first_wr_n = 1'b1;
        sda_t_n    = 1'b1;
      end
      default: begin
        unique case (state)
          ADDR: if (scl_rise) begin
            sr_n  = {sr[6:0], sda_f};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n = '0;
              if (sr[6:0] == TARGET_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = sda_f;
                re_n    = sda_f;
              end else begin
                state_n = IDLE;
                busy_n  = 1'b0;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (cnt == 4'd0) begin
              sda_t_n = 1'b0;
              cnt_n   = 4'd1;
            end else if (rw) begin
              state_n  = RD_BYTE;
              rd_go    = 1'b1;
              rd_first = 1'b1;
            end else begin
              state_n = WR_BYTE;
              sda_t_n = 1'b1;
              cnt_n   = '0;
            end
          end
          WR_BYTE: if (scl_rise) begin
            sr_n  = {sr[6:0], sda_f};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              state_n = WR_ACK;
              cnt_n   = '0;
              if (first_wr) begin
                addr_n     = sr_n;
                first_wr_n = 1'b0;
              end else begin
                wdata_n = sr_n;
                we_n    = 1'b1;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (cnt == 4'd0) begin
              sda_t_n = 1'b0;
              cnt_n   = 4'd1;
            end else begin
              state_n = WR_BYTE;
              sda_t_n = 1'b1;
              cnt_n   = '0;
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (cnt == 4'd8) begin
              state_n = RD_ACK;
              sda_t_n = 1'b1;
            end else begin
              rd_go    = 1'b1;
              rd_first = (cnt == 4'd0);
            end
          end
          RD_ACK: if (scl_rise) begin
            addr_n = rp.reg_addr_o + 8'd1;
            if (!sda_f) begin
              state_n = RD_BYTE;
              cnt_n   = '0;
              re_n    = 1'b1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    endcase
    if (rd_go) begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
      if (rd_first) begin
        hold_n  = 1'b1;
        sda_t_n = 1'b1;
        cnt_n   = '0;
      end else
`endif
      begin
        sda_t_n = sr[7];
        sr_n    = {sr[6:0], 1'b0};
        cnt_n   = rd_first ? 4'd1 : cnt + 4'd1;
      end
    end
`ifdef I2C_TARGET_CLK_STRETCH_EN
    if (stop || start) begin
      hold_n = 1'b0;
    end else if (hold && rp.reg_rdy_i) begin
      hold_n  = 1'b0;
      sda_t_n = rp.reg_rdata_i[7];
      sr_n    = {rp.reg_rdata_i[6:0], 1'b0};
      cnt_n   = 4'd1;
    end
`endif
  end

endmodule
